// File: rtl/alu_8bit_if.sv
// Operand/result bundle between the operand registers, opcode decoder and alu_8bit.
// The flags signal exists only when ALU_FLAGS_EN is defined.
interface alu_8bit_if;
    logic [7:0] a;
    logic [7:0] b;
    logic [3:0] s;
    logic [7:0] alu_result;
`ifdef ALU_FLAGS_EN
    logic [3:0] flags;
`endif

    modport master (
        output a, b, s,
        input  alu_result
`ifdef ALU_FLAGS_EN
        , input flags
`endif
    );

    modport slave (
        input  a, b, s,
        output alu_result
`ifdef ALU_FLAGS_EN
        , output flags
`endif
    );
endinterface

// File: rtl/alu_8bit.sv
// Registered 8-bit ALU: 16 operations evaluated combinationally, result registered each clk.
// Define ALU_FLAGS_EN to add the registered {carry, zero, negative, overflow} flags.
module alu_8bit (
    input  logic       clk,
    input  logic       rst,
    alu_8bit_if.slave  bus
);
    typedef enum logic [3:0] {
        OP_ADD, OP_SUB, OP_MUL, OP_DIV, OP_SHL, OP_SHR, OP_ROL, OP_ROR,
        OP_AND, OP_OR, OP_XOR, OP_NOR, OP_NAND, OP_XNOR, OP_GT, OP_EQ
    } op_t;

    op_t        op;
    logic [7:0] quot;
    logic [7:0] result_next;

    assign op = op_t'(bus.s);

    // Division by zero saturates to all ones instead of leaving the quotient undefined.
    assign quot = (bus.b == 8'h00) ? 8'hFF : bus.a / bus.b;

    always_comb begin
        result_next = 8'h00;
        case (op)
            OP_ADD:  result_next = bus.a + bus.b;
            OP_SUB:  result_next = bus.a - bus.b;
            OP_MUL:  result_next = bus.a * bus.b;
            OP_DIV:  result_next = quot;
            OP_SHL:  result_next = {bus.a[6:0], 1'b0};
            OP_SHR:  result_next = {1'b0, bus.a[7:1]};
            OP_ROL:  result_next = {bus.a[6:0], bus.a[7]};
            OP_ROR:  result_next = {bus.a[0], bus.a[7:1]};
            OP_AND:  result_next = bus.a & bus.b;
            OP_OR:   result_next = bus.a | bus.b;
            OP_XOR:  result_next = bus.a ^ bus.b;
            OP_NOR:  result_next = ~(bus.a | bus.b);
            OP_NAND: result_next = ~(bus.a & bus.b);
            OP_XNOR: result_next = ~(bus.a ^ bus.b);
            OP_GT:   result_next = {7'b0000000, bus.a > bus.b};
            OP_EQ:   result_next = {7'b0000000, bus.a == bus.b};
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst)
            bus.alu_result <= 8'h00;
        else
            bus.alu_result <= result_next;
    end

`ifdef ALU_FLAGS_EN
    logic carry_next;
    logic overflow_next;

    // Carry doubles as borrow for SUB and as the "high byte lost" indicator for MUL.
    always_comb begin
        carry_next    = 1'b0;
        overflow_next = 1'b0;
        case (op)
            OP_ADD: begin
                carry_next    = ({1'b0, bus.a} + {1'b0, bus.b}) > 9'd255;
                overflow_next = (bus.a[7] == bus.b[7]) && (result_next[7] != bus.a[7]);
            end
            OP_SUB: begin
                carry_next    = bus.a < bus.b;
                overflow_next = (bus.a[7] != bus.b[7]) && (result_next[7] != bus.a[7]);
            end
            OP_MUL:         carry_next = ({8'h00, bus.a} * {8'h00, bus.b}) > 16'd255;
            OP_DIV:         carry_next = (bus.b == 8'h00);
            OP_SHL, OP_ROL: carry_next = bus.a[7];
            OP_SHR, OP_ROR: carry_next = bus.a[0];
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst)
            bus.flags <= 4'b0000;
        else
            bus.flags <= {carry_next, result_next == 8'h00, result_next[7], overflow_next};
    end
`endif
endmodule

// File: tb/tb_alu_8bit.sv
// Self-checking bench for alu_8bit: directed vectors plus a back-to-back sweep,
// with expected results queued at drive time and popped one cycle later.
module tb_alu_8bit;
    logic clk;
    logic rst;

    alu_8bit_if bus ();

    alu_8bit dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] result;
        logic [3:0] flags;
        string      name;
    } exp_t;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [3:0] s;
        logic [7:0] res;
        string      name;
    } vec_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model built on plain integer arithmetic; flags packed {carry, zero, negative, overflow}.
    function automatic exp_t model(input logic [7:0] a, input logic [7:0] b,
                                   input logic [3:0] s, input string name);
        exp_t       e;
        int         ua   = int'(a);
        int         ub   = int'(b);
        int         sa   = int'($signed(a));
        int         sbv  = int'($signed(b));
        int         r    = 0;
        int         wide = 0;
        bit         c    = 1'b0;
        bit         v    = 1'b0;
        logic [7:0] res;
        case (s)
            4'h0: begin r = ua + ub; c = r > 255; wide = sa + sbv; v = (wide > 127) || (wide < -128); end
            4'h1: begin r = ua - ub; c = ua < ub; wide = sa - sbv; v = (wide > 127) || (wide < -128); end
            4'h2: begin r = ua * ub; c = r > 255; end
            4'h3: begin
                if (ub == 0) begin r = 255; c = 1'b1; end
                else r = ua / ub;
            end
            4'h4: begin r = ua * 2;                    c = ua > 127; end
            4'h5: begin r = ua / 2;                    c = (ua % 2) == 1; end
            4'h6: begin r = ua * 2 + ua / 128;         c = ua > 127; end
            4'h7: begin r = ua / 2 + (ua % 2) * 128;   c = (ua % 2) == 1; end
            4'h8: r = int'(a & b);
            4'h9: r = int'(a | b);
            4'hA: r = int'(a ^ b);
            4'hB: r = 255 - int'(a | b);
            4'hC: r = 255 - int'(a & b);
            4'hD: r = 255 - int'(a ^ b);
            4'hE: r = (ua > ub) ? 1 : 0;
            4'hF: r = (ua == ub) ? 1 : 0;
            default: r = 0;
        endcase
        res      = r[7:0];
        e.result = res;
        e.flags  = {c, res == 8'h00, res[7], v};
        e.name   = name;
        return e;
    endfunction

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1; bus.s = 4'h0; bus.a = 8'hFF; bus.b = 8'h01;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checks++;
            if (bus.alu_result !== 8'h00) begin
                errors++;
                $display("[TB] FAIL reset_result cycle %0d: got %h expected 00", i, bus.alu_result);
            end
`ifdef ALU_FLAGS_EN
            checks++;
            if (bus.flags !== 4'b0000) begin
                errors++;
                $display("[TB] FAIL reset_flags cycle %0d: got %b expected 0000", i, bus.flags);
            end
`endif
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.alu_result !== 8'h00) begin
            errors++;
            $display("[TB] FAIL release_result: got %h expected 00", bus.alu_result);
        end
`ifdef ALU_FLAGS_EN
        checks++;
        if (bus.flags !== 4'b1100) begin
            errors++;
            $display("[TB] FAIL release_flags: got %b expected 1100", bus.flags);
        end
`endif
    endtask

    // Directed vectors: each one is driven the cycle after the previous one, so the
    // result compared each cycle is the one launched a cycle earlier.
    task automatic test_directed(input string group);
        vec_t tbl[$];
        exp_t e;
        if (group == "arith") begin
            tbl.push_back('{8'h7E, 8'h5F, 4'h0, 8'hDD, "add_7E_5F"});
            tbl.push_back('{8'h43, 8'h02, 4'h1, 8'h41, "sub_43_02"});
            tbl.push_back('{8'hA3, 8'h21, 4'h2, 8'h03, "mul_A3_21"});
            tbl.push_back('{8'h77, 8'h4D, 4'h3, 8'h01, "div_77_4D"});
            tbl.push_back('{8'h10, 8'h00, 4'h3, 8'hFF, "div_by_zero"});
        end else if (group == "shift") begin
            tbl.push_back('{8'h45, 8'h9C, 4'h4, 8'h8A, "shl_45"});
            tbl.push_back('{8'h27, 8'h5A, 4'h5, 8'h13, "shr_27"});
            tbl.push_back('{8'hE2, 8'hFF, 4'h6, 8'hC5, "rol_E2"});
            tbl.push_back('{8'h2C, 8'h00, 4'h7, 8'h16, "ror_2C"});
        end else if (group == "logic") begin
            tbl.push_back('{8'hE0, 8'h13, 4'h8, 8'h00, "and_E0_13"});
            tbl.push_back('{8'h51, 8'h7E, 4'h9, 8'h7F, "or_51_7E"});
            tbl.push_back('{8'hD8, 8'h0F, 4'hA, 8'hD7, "xor_D8_0F"});
            tbl.push_back('{8'h19, 8'hB5, 4'hB, 8'h42, "nor_19_B5"});
            tbl.push_back('{8'h23, 8'h98, 4'hC, 8'hFF, "nand_23_98"});
            tbl.push_back('{8'h49, 8'h54, 4'hD, 8'hE2, "xnor_49_54"});
        end else begin
            tbl.push_back('{8'h08, 8'hAF, 4'hE, 8'h00, "gt_08_AF"});
            tbl.push_back('{8'hAF, 8'h08, 4'hE, 8'h01, "gt_AF_08"});
            tbl.push_back('{8'h63, 8'h27, 4'hF, 8'h00, "eq_63_27"});
            tbl.push_back('{8'h27, 8'h27, 4'hF, 8'h01, "eq_27_27"});
        end
        for (int i = 0; i <= tbl.size(); i++) begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                checks++;
                if (bus.alu_result !== e.result) begin
                    errors++;
                    $display("[TB] FAIL %s result: got %h expected %h", e.name, bus.alu_result, e.result);
                end
`ifdef ALU_FLAGS_EN
                checks++;
                if (bus.flags !== e.flags) begin
                    errors++;
                    $display("[TB] FAIL %s flags: got %b expected %b", e.name, bus.flags, e.flags);
                end
`endif
            end
            if (i < tbl.size()) begin
                bus.a = tbl[i].a; bus.b = tbl[i].b; bus.s = tbl[i].s;
                e = model(tbl[i].a, tbl[i].b, tbl[i].s, tbl[i].name);
                e.result = tbl[i].res;
                sb.push_back(e);
            end
        end
    endtask

    task automatic test_mid_reset();
        exp_t e;
        @(negedge clk);
        bus.a = 8'h7E; bus.b = 8'h5F; bus.s = 4'h0;
        sb.push_back(model(8'h7E, 8'h5F, 4'h0, "pre_reset_add"));
        @(negedge clk);
        e = sb.pop_front();
        checks++;
        if (bus.alu_result !== e.result) begin
            errors++;
            $display("[TB] FAIL %s result: got %h expected %h", e.name, bus.alu_result, e.result);
        end
        rst = 1'b1; bus.a = 8'hA3; bus.b = 8'h21; bus.s = 4'h2;
        @(negedge clk);
        checks++;
        if (bus.alu_result !== 8'h00) begin
            errors++;
            $display("[TB] FAIL mid_reset_result: got %h expected 00", bus.alu_result);
        end
`ifdef ALU_FLAGS_EN
        checks++;
        if (bus.flags !== 4'b0000) begin
            errors++;
            $display("[TB] FAIL mid_reset_flags: got %b expected 0000", bus.flags);
        end
`endif
        rst = 1'b0; bus.a = 8'h43; bus.b = 8'h02; bus.s = 4'h1;
        sb.push_back(model(8'h43, 8'h02, 4'h1, "post_reset_sub"));
        @(negedge clk);
        e = sb.pop_front();
        checks++;
        if (bus.alu_result !== e.result) begin
            errors++;
            $display("[TB] FAIL %s result: got %h expected %h", e.name, bus.alu_result, e.result);
        end
    endtask

    // New opcode and operands every cycle, three sweeps of all 16 codes.
    task automatic test_back_to_back();
        exp_t       e;
        logic [7:0] ra, rb;
        for (int i = 0; i <= 48; i++) begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                checks++;
                if (bus.alu_result !== e.result) begin
                    errors++;
                    $display("[TB] FAIL %s result: got %h expected %h", e.name, bus.alu_result, e.result);
                end
`ifdef ALU_FLAGS_EN
                checks++;
                if (bus.flags !== e.flags) begin
                    errors++;
                    $display("[TB] FAIL %s flags: got %b expected %b", e.name, bus.flags, e.flags);
                end
`endif
            end
            if (i < 48) begin
                ra = 8'($urandom_range(0, 255));
                rb = 8'($urandom_range(0, 255));
                if (i == 3) rb = 8'h00;
                if (i == 31) rb = ra;
                bus.a = ra; bus.b = rb; bus.s = 4'(i % 16);
                sb.push_back(model(ra, rb, 4'(i % 16),
                                   $sformatf("b2b_%0d_s%h_%h_%h", i, 4'(i % 16), ra, rb)));
            end
        end
    endtask

    initial begin
        rst = 1'b1; bus.a = 8'h00; bus.b = 8'h00; bus.s = 4'h0;
        test_reset();
        test_directed("arith");
        test_directed("shift");
        test_directed("logic");
        test_directed("compare");
        test_mid_reset();
        test_back_to_back();
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL scoreboard_leftover: got %0d entries expected 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end
endmodule
